muldiv_unit: RTL and testbench

- Parametrised iterative multiply/divide unit that adds the RISC-V M extension (plus W variants when XLEN=64) to the execute stage of the pipelined core.
- Sits beside the ALU. Accepts one operation via a valid/ready handshake and computes the result radix-2, one bit per cycle.
- Returns the result and destination tag via a second valid/ready handshake. The hazard controller holds the pipeline while busy is high.
- Supports flush on taken branch/jump.

---
 rtl/muldiv_unit.sv | 236 +++++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative radix-2 multiply/divide unit implementing RISC-V M
// (and the *W variants when XLEN=64) beside the ALU in the execute stage.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   flush               kill any in-flight operation (branch/jump redirect)
//   in_valid/in_ready   request handshake; in_ready is high only in IDLE
//   in_funct3, in_is_w  operation select (RISC-V funct3, OP-32 flag)
//   in_rs1, in_rs2      operands (dividend/multiplicand, divisor/multiplier)
//   in_rd               destination tag carried through to out_rd
//   out_valid/out_ready result handshake; result and tag held until taken
//   out_result, out_rd  result and its destination tag
//   busy                high while an operation is in CALC or DONE
//
// Timing: the accept edge moves IDLE->CALC (or straight to DONE for the
// divide-by-zero / signed-overflow fast paths). CALC performs one iteration
// per edge and moves to DONE on the edge of its ITER-th iteration, so
// out_valid is seen ITER+1 edges after the request is presented, counting
// the accept edge as the first.
module muldiv_unit #(
  parameter int unsigned XLEN     = 64,
  parameter int unsigned W_OPS_EN = 1,
  parameter int unsigned TAG_W    = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_funct3,
  input  logic             in_is_w,
  input  logic [XLEN-1:0]  in_rs1,
  input  logic [XLEN-1:0]  in_rs2,
  input  logic [TAG_W-1:0] in_rd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_rd,
  output logic             busy
);

  localparam int unsigned CntW = $clog2(XLEN + 1);
  localparam bit          WEn  = (W_OPS_EN != 0) && (XLEN == 64);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  function automatic logic [XLEN-1:0] sext32(input logic [XLEN-1:0] x);
    logic [XLEN-1:0] y;
    y = x;
    for (int i = 32; i < XLEN; i++) y[i] = x[31];
    return y;
  endfunction

  function automatic logic [XLEN-1:0] zext32(input logic [XLEN-1:0] x);
    logic [XLEN-1:0] y;
    y = '0;
    y[31:0] = x[31:0];
    return y;
  endfunction

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [2:0]        funct3_q, funct3_d;
  logic              w_q, w_d;
  logic              sa_q, sa_d;     // rs1 was negative (signed interpretation)
  logic              sb_q, sb_d;     // rs2 was negative (signed interpretation)
  logic [2*XLEN-1:0] a_q, a_d;       // mul: shifting multiplicand; div: divisor
  logic [XLEN-1:0]   b_q, b_d;       // mul: shifting multiplier; div: dividend/quotient
  logic [2*XLEN-1:0] acc_q, acc_d;   // mul: product; div: partial remainder
  logic [XLEN-1:0]   result_q, result_d;
  logic [TAG_W-1:0]  rd_q, rd_d;

  // Accept-time decode
  logic              w_eff, sgn_a, sgn_b, neg_a, neg_b, div_zero, div_ovf;
  logic [XLEN-1:0]   ext_a, ext_b, mag_a, mag_b, min_neg, fast_res;
  // Iteration datapath
  logic [XLEN:0]     rem_sh;
  logic              rem_ge;
  logic [XLEN-1:0]   rem_nx, b_nx, quo, rem, res;
  logic [2*XLEN-1:0] acc_nx, a_nx, prod;
  logic [CntW-1:0]   iter_last;

  always_comb begin
    w_eff = WEn && in_is_w && ((in_funct3 == 3'b000) || in_funct3[2]);
    // MUL low bits are sign-agnostic, so it goes down the signed path.
    sgn_a = (in_funct3 != 3'b011) && (in_funct3 != 3'b101) && (in_funct3 != 3'b111);
    sgn_b = (in_funct3 == 3'b000) || (in_funct3 == 3'b001) ||
            (in_funct3 == 3'b100) || (in_funct3 == 3'b110);
    ext_a = in_rs1;
    ext_b = in_rs2;
    if (w_eff) begin
      ext_a = sgn_a ? sext32(in_rs1) : zext32(in_rs1);
      ext_b = sgn_b ? sext32(in_rs2) : zext32(in_rs2);
    end
    neg_a = sgn_a && ext_a[XLEN-1];
    neg_b = sgn_b && ext_b[XLEN-1];
    mag_a = neg_a ? -ext_a : ext_a;
    mag_b = neg_b ? -ext_b : ext_b;

    min_neg  = w_eff ? ({XLEN{1'b1}} << 31) : (XLEN'(1) << (XLEN - 1));
    div_zero = in_funct3[2] && (ext_b == '0);
    div_ovf  = in_funct3[2] && !in_funct3[0] && (ext_a == min_neg) && (ext_b == '1);
    if (div_zero) fast_res = in_funct3[1] ? ext_a : '1;
    else          fast_res = in_funct3[1] ? '0 : ext_a;
    if (w_eff) fast_res = sext32(fast_res);
  end

  always_comb begin
    iter_last = w_q ? CntW'(31) : CntW'(XLEN - 1);

    // Restoring division step: shift in next dividend bit, subtract if it fits.
    rem_sh = {acc_q[XLEN-1:0], b_q[XLEN-1]};
    rem_ge = rem_sh >= {1'b0, a_q[XLEN-1:0]};
    rem_nx = rem_ge ? XLEN'(rem_sh - {1'b0, a_q[XLEN-1:0]}) : rem_sh[XLEN-1:0];

    if (funct3_q[2]) begin
      acc_nx = {{XLEN{1'b0}}, rem_nx};
      a_nx   = a_q;
      b_nx   = {b_q[XLEN-2:0], rem_ge};
    end else begin
      acc_nx = b_q[0] ? acc_q + a_q : acc_q;
      a_nx   = a_q << 1;
      b_nx   = b_q >> 1;
    end

    prod = (sa_q ^ sb_q) ? -acc_nx : acc_nx;
    quo  = (sa_q ^ sb_q) ? -b_nx : b_nx;
    rem  = sa_q ? -acc_nx[XLEN-1:0] : acc_nx[XLEN-1:0];
    unique case (funct3_q)
      3'b000:                 res = prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: res = prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:         res = quo;
      default:                res = rem;
    endcase
    if (w_q) res = sext32(res);
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    funct3_d = funct3_q;
    w_d      = w_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    result_d = result_q;
    rd_d     = rd_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid && !flush) begin
          funct3_d = in_funct3;
          w_d      = w_eff;
          sa_d     = neg_a;
          sb_d     = neg_b;
          rd_d     = in_rd;
          cnt_d    = '0;
          acc_d    = '0;
          if (in_funct3[2]) begin
            a_d = {{XLEN{1'b0}}, mag_b};
            // W divides run 32 steps, so park the 32-bit dividend at the top.
            b_d = w_eff ? (mag_a << (XLEN - 32)) : mag_a;
          end else begin
            a_d = {{XLEN{1'b0}}, mag_a};
            b_d = mag_b;
          end
          if (div_zero || div_ovf) begin
            result_d = fast_res;
            state_d  = StDone;
          end else begin
            state_d = StCalc;
          end
        end
      end
      StCalc: begin
        acc_d = acc_nx;
        a_d   = a_nx;
        b_d   = b_nx;
        if (cnt_q == iter_last) begin
          cnt_d    = '0;
          result_d = res;
          state_d  = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (flush) begin
      state_d  = StIdle;
      cnt_d    = '0;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      funct3_q <= '0;
      w_q      <= 1'b0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      result_q <= '0;
      rd_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      funct3_q <= funct3_d;
      w_q      <= w_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      rd_q     <= rd_d;
    end
  end

  assign in_ready   = (state_q == StIdle);
  assign out_valid  = (state_q == StDone);
  assign busy       = (state_q != StIdle);
  assign out_result = result_q;
  assign out_rd     = rd_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit (XLEN=64). Stimulus pushes the expected
// result/tag; a negedge monitor pops and compares on each output handshake.
// Latency is counted in edges with the accept edge as edge 1.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_funct3;
  logic        in_is_w;
  logic [63:0] in_rs1;
  logic [63:0] in_rs2;
  logic [4:0]  in_rd;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_result;
  logic [4:0]  out_rd;
  logic        busy;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [63:0] res;
    logic [4:0]  rd;
    string       name;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  muldiv_unit #(
    .XLEN    (64),
    .W_OPS_EN(1),
    .TAG_W   (5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_funct3 (in_funct3),
    .in_is_w   (in_is_w),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_rd     (in_rd),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_result(out_result),
    .out_rd    (out_rd),
    .busy      (busy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  // Monitor: compare on every accepted result.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_result: got 0x%h, expected no result", out_result);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk({e.name, "_result"}, out_result, e.res);
        chk({e.name, "_rd"}, {59'b0, out_rd}, {59'b0, e.rd});
      end
    end
  end

  // Present a request at negedge; returns at accept edge + 1.
  task automatic issue(input logic [2:0] f, input logic w, input logic [63:0] a,
                       input logic [63:0] b, input logic [4:0] rd);
    @(negedge clk);
    in_valid  = 1'b1;
    in_funct3 = f;
    in_is_w   = w;
    in_rs1    = a;
    in_rs2    = b;
    in_rd     = rd;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string name, input int exp_lat);
    int lat;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({name, "_latency"}, 64'(lat), 64'(exp_lat));
  endtask

  task automatic run_op(input string name, input logic [2:0] f, input logic w,
                        input logic [63:0] a, input logic [63:0] b, input logic [4:0] rd,
                        input logic [63:0] exp, input int exp_lat);
    exp_t e;
    e.res  = exp;
    e.rd   = rd;
    e.name = name;
    exp_q.push_back(e);
    issue(f, w, a, b, rd);
    wait_valid(name, exp_lat);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int vcount;
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_funct3 = '0;
    in_is_w   = 1'b0;
    in_rs1    = '0;
    in_rs2    = '0;
    in_rd     = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready", {63'b0, in_ready}, 64'd1);
    chk("reset_out_valid", {63'b0, out_valid}, 64'd0);
    chk("reset_busy", {63'b0, busy}, 64'd0);
    chk("reset_out_result", out_result, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op("mul_7_m3", 3'b000, 1'b0, 64'd7, -64'sd3, 5'd5, 64'hFFFF_FFFF_FFFF_FFEB, 65);
    run_op("mulhu", 3'b011, 1'b0, '1, 64'd2, 5'd6, 64'd1, 65);
    run_op("mulh", 3'b001, 1'b0, '1, 64'd2, 5'd7, '1, 65);
    run_op("mulhsu", 3'b010, 1'b0, '1, 64'd2, 5'd8, '1, 65);
    run_op("mulh_w_ignored", 3'b001, 1'b1, '1, 64'd2, 5'd8, '1, 65);
    run_op("div_m7_2", 3'b100, 1'b0, -64'sd7, 64'd2, 5'd9, 64'hFFFF_FFFF_FFFF_FFFD, 65);
    run_op("rem_m7_2", 3'b110, 1'b0, -64'sd7, 64'd2, 5'd10, '1, 65);
    run_op("divu_100_7", 3'b101, 1'b0, 64'd100, 64'd7, 5'd11, 64'd14, 65);
    run_op("remu_100_7", 3'b111, 1'b0, 64'd100, 64'd7, 5'd12, 64'd2, 65);
    run_op("divu_by0", 3'b101, 1'b0, 64'd5, 64'd0, 5'd13, '1, 1);
    run_op("rem_by0", 3'b110, 1'b0, 64'd5, 64'd0, 5'd14, 64'd5, 1);
    run_op("div_ovf", 3'b100, 1'b0, 64'h8000_0000_0000_0000, '1, 5'd15,
           64'h8000_0000_0000_0000, 1);
    run_op("rem_ovf", 3'b110, 1'b0, 64'h8000_0000_0000_0000, '1, 5'd16, 64'd0, 1);
    run_op("divw", 3'b100, 1'b1, 64'h0000_0001_8000_0000, 64'd1, 5'd17,
           64'hFFFF_FFFF_8000_0000, 33);
    run_op("mulw", 3'b000, 1'b1, 64'h0000_0000_7FFF_FFFF, 64'd2, 5'd18,
           64'hFFFF_FFFF_FFFF_FFFE, 33);
    run_op("divuw", 3'b101, 1'b1, 64'hFFFF_FFFF_8000_0000, 64'd2, 5'd19,
           64'h0000_0000_4000_0000, 33);

    // Flush together with in_valid: request must be dropped.
    @(negedge clk);
    in_valid = 1'b1;
    flush    = 1'b1;
    in_funct3 = 3'b000;
    in_rs1   = 64'd9;
    in_rs2   = 64'd9;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush    = 1'b0;
    chk("flush_with_valid_busy", {63'b0, busy}, 64'd0);

    // Flush 10 cycles into CALC.
    issue(3'b000, 1'b0, 64'd5, 64'd5, 5'd3);
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("flush_in_ready", {63'b0, in_ready}, 64'd1);
    chk("flush_busy", {63'b0, busy}, 64'd0);
    vcount = 0;
    repeat (80) begin
      @(posedge clk);
      #1;
      if (out_valid) vcount++;
    end
    chk("flush_no_valid", 64'(vcount), 64'd0);
    run_op("mul_3_4", 3'b000, 1'b0, 64'd3, 64'd4, 5'd4, 64'd12, 65);

    // Backpressure in DONE.
    begin
      exp_t e;
      e.res  = 64'd42;
      e.rd   = 5'd21;
      e.name = "mul_bp";
      exp_q.push_back(e);
    end
    out_ready = 1'b0;
    issue(3'b000, 1'b0, 64'd6, 64'd7, 5'd21);
    wait_valid("mul_bp", 65);
    vcount = 0;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (out_result !== 64'd42 || out_rd !== 5'd21 || busy !== 1'b1 ||
          out_valid !== 1'b1) vcount++;
    end
    chk("backpressure_hold", 64'(vcount), 64'd0);
    out_ready = 1'b1;
    @(posedge clk);
    #1;

    // Asynchronous reset mid-CALC.
    issue(3'b101, 1'b0, 64'd1000, 64'd3, 5'd30);
    repeat (10) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("areset_out_valid", {63'b0, out_valid}, 64'd0);
    chk("areset_out_result", out_result, 64'd0);
    chk("areset_out_rd", {59'b0, out_rd}, 64'd0);
    chk("areset_busy", {63'b0, busy}, 64'd0);
    chk("areset_in_ready", {63'b0, in_ready}, 64'd1);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
